// File: rtl/elevator_scheduler.sv
// Collective-control (SCAN) scheduler for a 4-floor car: latches hall/car calls,
// times floor-to-floor travel and door dwell, and drives floor/direction/door/lamp outputs.
module elevator_scheduler #(
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] u,
  input  logic [3:0] d,
  input  logic [3:0] i,
  output logic [2:0] F,
  output logic [1:0] dir,
  output logic       door,
  output logic [3:0] lamp_u,
  output logic [3:0] lamp_d,
  output logic [3:0] lamp_i
);

  localparam int MW = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYC - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYC - 1);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      floor_q, floor_d;
  logic [1:0]      dir_q, dir_d;
  logic [MW-1:0]   mtimer_q, mtimer_d;
  logic [DW-1:0]   dtimer_q, dtimer_d;
  logic [3:0]      lamp_u_q, lamp_u_d;
  logic [3:0]      lamp_d_q, lamp_d_d;
  logic [3:0]      lamp_i_q, lamp_i_d;

  // Pending view: latched lamps merged with this cycle's inputs.
  logic [3:0] pu, pd, pi, pall;
  logic [3:0] clr_u, clr_d, clr_i;
  logic [1:0] f_idx, n_idx;
  logic [3:0] f_oh, n_oh;
  logic       here, above, below;
  logic       n_above, n_below, stop;
  logic       reopen, ahead, behind, opp_here;

  function automatic logic calls_above(input logic [3:0] m, input logic [1:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > int'(idx) && m[k]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic calls_below(input logic [3:0] m, input logic [1:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(idx) && m[k]) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    mtimer_d = mtimer_q;
    dtimer_d = dtimer_q;
    clr_u    = '0;
    clr_d    = '0;
    clr_i    = '0;
    stop     = 1'b0;
    reopen   = 1'b0;
    ahead    = 1'b0;
    behind   = 1'b0;
    opp_here = 1'b0;

    pu    = lamp_u_q | u;
    pd    = lamp_d_q | d;
    pi    = lamp_i_q | i;
    pall  = pu | pd | pi;
    f_idx = 2'(floor_q - 3'd1);
    f_oh  = 4'b0001 << f_idx;
    here  = pall[f_idx];
    above = calls_above(pall, f_idx);
    below = calls_below(pall, f_idx);

    n_idx   = (dir_q == DIR_UP) ? f_idx + 2'd1 : f_idx - 2'd1;
    n_oh    = 4'b0001 << n_idx;
    n_above = calls_above(pall, n_idx);
    n_below = calls_below(pall, n_idx);

    unique case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d  = S_DOOR;
          dtimer_d = '0;
          clr_u    = f_oh;
          clr_d    = f_oh;
          clr_i    = f_oh;
        end else if (above) begin
          state_d  = S_MOVE;
          dir_d    = DIR_UP;
          mtimer_d = '0;
        end else if (below) begin
          state_d  = S_MOVE;
          dir_d    = DIR_DN;
          mtimer_d = '0;
        end
      end

      S_MOVE: begin
        if (mtimer_q == MOVE_LAST) begin
          mtimer_d = '0;
          floor_d  = (dir_q == DIR_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
          // Stop test is evaluated at the floor being entered on this edge.
          if (dir_q == DIR_UP) begin
            stop = pi[n_idx] | pu[n_idx] | (pd[n_idx] & ~n_above);
            if (stop) begin
              clr_i = n_oh;
              clr_u = n_oh;
              if (!n_above) clr_d = n_oh;
            end
          end else begin
            stop = pi[n_idx] | pd[n_idx] | (pu[n_idx] & ~n_below);
            if (stop) begin
              clr_i = n_oh;
              clr_d = n_oh;
              if (!n_below) clr_u = n_oh;
            end
          end
          if (stop) begin
            state_d  = S_DOOR;
            dtimer_d = '0;
          end
        end else begin
          mtimer_d = mtimer_q + MW'(1);
        end
      end

      S_DOOR: begin
        unique case (dir_q)
          DIR_UP:  reopen = pi[f_idx] | pu[f_idx];
          DIR_DN:  reopen = pi[f_idx] | pd[f_idx];
          default: reopen = here;
        endcase
        unique case (dir_q)
          DIR_UP: begin
            ahead    = above;
            behind   = below;
            opp_here = pd[f_idx];
          end
          DIR_DN: begin
            ahead    = below;
            behind   = above;
            opp_here = pu[f_idx];
          end
          default: ;
        endcase

        if (reopen) begin
          dtimer_d = '0;
          clr_i    = f_oh;
          if (dir_q != DIR_DN) clr_u = f_oh;
          if (dir_q != DIR_UP) clr_d = f_oh;
        end else if (dtimer_q == DOOR_LAST) begin
          mtimer_d = '0;
          if (dir_q == DIR_IDLE) begin
            if (above) begin
              state_d = S_MOVE;
              dir_d   = DIR_UP;
            end else if (below) begin
              state_d = S_MOVE;
              dir_d   = DIR_DN;
            end else begin
              state_d = S_IDLE;
            end
          end else if (ahead) begin
            state_d = S_MOVE;
          end else if (behind) begin
            dir_d = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
            // A waiting hall call here in the new direction is served before leaving.
            if (opp_here) begin
              dtimer_d = '0;
              if (dir_q == DIR_UP) clr_d = f_oh;
              else                 clr_u = f_oh;
            end else begin
              state_d = S_MOVE;
            end
          end else begin
            state_d = S_IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          dtimer_d = dtimer_q + DW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase

    // Clearing wins over a same-cycle set of the same bit.
    lamp_u_d = pu & ~clr_u;
    lamp_d_d = pd & ~clr_d;
    lamp_i_d = pi & ~clr_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      floor_q  <= 3'd1;
      dir_q    <= DIR_IDLE;
      mtimer_q <= '0;
      dtimer_q <= '0;
      lamp_u_q <= '0;
      lamp_d_q <= '0;
      lamp_i_q <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      mtimer_q <= mtimer_d;
      dtimer_q <= dtimer_d;
      lamp_u_q <= lamp_u_d;
      lamp_d_q <= lamp_d_d;
      lamp_i_q <= lamp_i_d;
    end
  end

  assign F      = floor_q;
  assign dir    = dir_q;
  assign door   = (state_q == S_DOOR);
  assign lamp_u = lamp_u_q;
  assign lamp_d = lamp_d_q;
  assign lamp_i = lamp_i_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: each scenario queues its hand-derived output changes (with edge
// numbers); a monitor pops and compares each time the DUT outputs change.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] u, d, i;
  logic [2:0] F;
  logic [1:0] dir;
  logic       door;
  logic [3:0] lamp_u, lamp_d, lamp_i;

  elevator_scheduler #(.MOVE_CYC(4), .DOOR_CYC(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .u      (u),
    .d      (d),
    .i      (i),
    .F      (F),
    .dir    (dir),
    .door   (door),
    .lamp_u (lamp_u),
    .lamp_d (lamp_d),
    .lamp_i (lamp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] f;
    logic [1:0] dir;
    logic       door;
    logic [3:0] lu;
    logic [3:0] ld;
    logic [3:0] li;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_n = -100;
  string tname  = "init";

  // Edge number since reset release: value seen after edge t is t; the reset edge reads -1.
  always @(posedge clk) edge_n <= reset ? -1 : edge_n + 1;

  task automatic check(input string name, input logic ok, input string act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, required %s", name, act, req);
    end
  endtask

  function automatic string fmt(input int cyc, input snap_t s);
    return $sformatf("edge=%0d F=%0d dir=%b door=%b lu=%b ld=%b li=%b",
                     cyc, s.f, s.dir, s.door, s.lu, s.ld, s.li);
  endfunction

  snap_t prev_s, cur_s;
  exp_t  ex;

  always @(negedge clk) begin
    if (edge_n >= -1) begin
      cur_s = {F, dir, door, lamp_u, lamp_d, lamp_i};
      if (edge_n == -1 || cur_s !== prev_s) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s unexpected", tname), 1'b0, fmt(edge_n, cur_s), "no output change");
        end else begin
          ex = exp_q.pop_front();
          check(tname, (ex.cyc == edge_n) && (cur_s === ex.s),
                fmt(edge_n, cur_s), fmt(ex.cyc, ex.s));
        end
      end
      prev_s = cur_s;
    end
  end

  task automatic push_exp(input int cyc, input logic [2:0] ff, input logic [1:0] dd,
                          input logic dr, input logic [3:0] lu, input logic [3:0] ld,
                          input logic [3:0] li);
    exp_t e;
    e.cyc = cyc;
    e.s   = {ff, dd, dr, lu, ld, li};
    exp_q.push_back(e);
  endtask

  task automatic at_edge(input int n);
    int g;
    g = 0;
    while (edge_n != n - 1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check($sformatf("%s timeout", tname), 1'b0, "no progress", $sformatf("edge %0d", n));
  endtask

  task automatic pulse(input int n, input logic [3:0] uu, input logic [3:0] dd, input logic [3:0] ii);
    at_edge(n);
    u = uu;
    d = dd;
    i = ii;
    @(negedge clk);
    u = '0;
    d = '0;
    i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic finish_test(input int n);
    at_edge(n + 1);
    check($sformatf("%s drained", tname), exp_q.size() == 0,
          $sformatf("%0d outstanding", exp_q.size()), "0 outstanding");
    exp_q.delete();
  endtask

  initial begin
    u = '0;
    d = '0;
    i = '0;
    reset = 1'b1;

    tname = "up_call";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    push_exp( 4, 3'd2, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 7, 3'd2, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0010, 4'b0000, 4'b0000);
    finish_test(12);

    tname = "down_then_car";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    push_exp( 4, 3'd2, 2'b01, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    push_exp( 8, 3'd3, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 9, 3'd3, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0001);
    push_exp(11, 3'd3, 2'b10, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    push_exp(15, 3'd2, 2'b10, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    push_exp(19, 3'd1, 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp(22, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0000, 4'b0100, 4'b0000);
    pulse(9, 4'b0000, 4'b0000, 4'b0001);
    finish_test(27);

    tname = "up_up_collect";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    push_exp( 2, 3'd1, 2'b01, 1'b0, 4'b0010, 4'b0000, 4'b1000);
    push_exp( 4, 3'd2, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b1000);
    push_exp( 5, 3'd2, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b1100);
    push_exp( 7, 3'd2, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b1100);
    push_exp(11, 3'd3, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b1000);
    push_exp(14, 3'd3, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    push_exp(18, 3'd4, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp(21, 3'd4, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0000, 4'b0000, 4'b1000);
    pulse(2, 4'b0010, 4'b0000, 4'b0000);
    pulse(5, 4'b0000, 4'b0000, 4'b0100);
    finish_test(26);

    tname = "reversal";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    push_exp( 2, 3'd1, 2'b01, 1'b0, 4'b0000, 4'b0100, 4'b1000);
    push_exp( 4, 3'd2, 2'b01, 1'b0, 4'b0000, 4'b0100, 4'b1000);
    push_exp( 8, 3'd3, 2'b01, 1'b0, 4'b0000, 4'b0100, 4'b1000);
    push_exp(12, 3'd4, 2'b01, 1'b1, 4'b0000, 4'b0100, 4'b0000);
    push_exp(15, 3'd4, 2'b10, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    push_exp(19, 3'd3, 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp(22, 3'd3, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0000, 4'b0000, 4'b1000);
    pulse(2, 4'b0000, 4'b0100, 4'b0000);
    finish_test(27);

    tname = "door_hold";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    push_exp( 4, 3'd2, 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp(10, 3'd2, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0010, 4'b0000, 4'b0000);
    pulse(7, 4'b0000, 4'b0000, 4'b0010);
    finish_test(15);

    tname = "serve_before_reverse";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    push_exp( 2, 3'd1, 2'b01, 1'b0, 4'b0001, 4'b0000, 4'b0010);
    push_exp( 4, 3'd2, 2'b01, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    push_exp( 5, 3'd2, 2'b01, 1'b1, 4'b0001, 4'b0010, 4'b0000);
    push_exp( 7, 3'd2, 2'b10, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    push_exp(10, 3'd2, 2'b10, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    push_exp(14, 3'd1, 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp(17, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0000, 4'b0000, 4'b0010);
    pulse(2, 4'b0001, 4'b0000, 4'b0000);
    pulse(5, 4'b0000, 4'b0010, 4'b0000);
    finish_test(22);

    tname = "idle_here_reopen";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b00, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 5, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b0001, 4'b0000, 4'b0000);
    pulse(2, 4'b0000, 4'b0001, 4'b0000);
    finish_test(10);

    tname = "reset_mid_move";
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    push_exp( 0, 3'd1, 2'b01, 1'b0, 4'b1000, 4'b0000, 4'b0000);
    push_exp( 4, 3'd2, 2'b01, 1'b0, 4'b1000, 4'b0000, 4'b0000);
    push_exp(-1, 3'd1, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    pulse(0, 4'b1000, 4'b0000, 4'b0000);
    at_edge(6);
    reset = 1'b1;
    u     = 4'b0100;
    @(negedge clk);
    reset = 1'b0;
    u     = 4'b0000;
    finish_test(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
